// File: rtl/twiddle_seq.sv
`default_nettype none
// =============================================================================
// Module  : twiddle_seq
// Brief   : Address/twiddle sequencer for a radix-2 8-point FFT (3 stages x 4
//           butterflies) with valid/ready step handshake.
// Revision: 1.0 - initial release
// =============================================================================
module twiddle_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inv,
    input  logic       ready,
    output logic       busy,
    output logic       valid,
    output logic [1:0] stage,
    output logic [2:0] addr_a,
    output logic [2:0] addr_b,
    output logic [2:0] w,
    output logic       last,
    output logic       done
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [1:0] j_q,     j_d;
    logic       inv_q,   inv_d;

    logic       w_final;
    logic [2:0] w_a;
    logic [2:0] w_b;
    logic [2:0] w_k;

    assign w_final = (stage_q == 2'd2) && (j_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_IDLE;
            stage_q <= 2'd0;
            j_q     <= 2'd0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        inv_d   = inv_q;
        case (state_q)
            C_IDLE: begin
                if (start) begin
                    state_d = C_RUN;
                    inv_d   = inv;
                    stage_d = 2'd0;
                    j_d     = 2'd0;
                end
            end
            C_RUN: begin
                if (ready) begin
                    if (w_final) begin
                        state_d = C_DONE;
                        stage_d = 2'd0;
                        j_d     = 2'd0;
                    end else begin
                        // j wraps 3->0 on its own; stage steps on that wrap
                        j_d = j_q + 2'd1;
                        if (j_q == 2'd3) begin
                            stage_d = stage_q + 2'd1;
                        end
                    end
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // Per-stage closed forms of grp*2*span+pos, addr_a+span and pos<<(2-stage)
    always_comb begin
        w_a = 3'd0;
        w_b = 3'd0;
        w_k = 3'd0;
        case (stage_q)
            2'd0: begin
                w_a = {j_q, 1'b0};
                w_b = {j_q, 1'b1};
                w_k = 3'd0;
            end
            2'd1: begin
                w_a = {j_q[1], 1'b0, j_q[0]};
                w_b = {j_q[1], 1'b1, j_q[0]};
                w_k = {1'b0, j_q[0], 1'b0};
            end
            2'd2: begin
                w_a = {1'b0, j_q};
                w_b = {1'b1, j_q};
                w_k = {1'b0, j_q};
            end
            default: begin
                w_a = 3'd0;
                w_b = 3'd0;
                w_k = 3'd0;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == C_RUN) || (state_q == C_DONE);
        valid  = (state_q == C_RUN);
        done   = (state_q == C_DONE);
        stage  = 2'd0;
        addr_a = 3'd0;
        addr_b = 3'd0;
        w      = 3'd0;
        last   = 1'b0;
        if (state_q == C_RUN) begin
            stage  = stage_q;
            addr_a = w_a;
            addr_b = w_b;
            w      = inv_q ? (3'd0 - w_k) : w_k;
            last   = w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`default_nettype none
// =============================================================================
// Module  : tb_twiddle_seq
// Brief   : Scoreboard bench for twiddle_seq (forward/inverse, stall, ignored
//           start, mid-run reset).
// Revision: 1.0 - initial release
// =============================================================================
module tb_twiddle_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       inv = 1'b0;
    logic       ready = 1'b1;
    logic       busy, valid, last, done;
    logic [1:0] stage;
    logic [2:0] addr_a, addr_b, w;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] mon_obs;

    int tab_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tab_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tab_wf [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int tab_wi [12] = '{0, 0, 0, 0, 0, 6, 0, 6, 0, 7, 6, 5};

    twiddle_seq u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .inv    (inv),
        .ready  (ready),
        .busy   (busy),
        .valid  (valid),
        .stage  (stage),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .w      (w),
        .last   (last),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_expected(input logic inv_i);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({2'(i / 4), 3'(tab_a[i]), 3'(tab_b[i]),
                             3'(inv_i ? tab_wi[i] : tab_wf[i]), 1'(i == 11)});
        end
    endtask

    // Step outputs {stage,a,b,w,last} compared against the queue head every
    // valid cycle, so a stalled step is re-checked until its handshake.
    always @(negedge clk) begin
        mon_obs = {stage, addr_a, addr_b, w, last};
        if (valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check_val("step", {20'd0, mon_obs}, {20'd0, exp_q[0]});
                check_val("busy_in_run", {31'd0, busy}, 32'd1);
                if (ready) void'(exp_q.pop_front());
            end
        end else begin
            check_val("idle_outputs_zero", {20'd0, mon_obs}, 32'd0);
        end
    end

    // Called at posedge+1; drives start now so the next edge accepts it.
    task automatic run_transform(input logic inv_i, input bit stall, input bit poke,
                                 input int abort_at, input int exp_lat);
        int lat;
        lat   = 0;
        start = 1'b1;
        inv   = inv_i;
        push_expected(inv_i);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start = 1'b0;
                inv   = ~inv_i;
            end
            if (stall && n == 6) ready = 1'b0;
            if (stall && n == 9) ready = 1'b1;
            if (poke && n == 4) start = 1'b1;
            if (poke && n == 5) start = 1'b0;
            if (abort_at == n) begin
                #2 rst = 1'b1;
                #1;
                check_val("abort_valid", {31'd0, valid}, 32'd0);
                check_val("abort_busy", {31'd0, busy}, 32'd0);
                check_val("abort_done", {31'd0, done}, 32'd0);
                check_val("abort_outputs", {20'd0, stage, addr_a, addr_b, w, last}, 32'd0);
                exp_q.delete();
                return;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check_val("done_latency", lat, exp_lat);
        check_val("queue_drained", exp_q.size(), 32'd0);
        check_val("done_cycle_valid", {31'd0, valid}, 32'd0);
        if (poke) start = 1'b1;
        @(posedge clk);
        #1;
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_val("no_restart_valid", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_valid", {31'd0, valid}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_outputs", {20'd0, stage, addr_a, addr_b, w, last}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_transform(1'b0, 1'b0, 1'b0, 0, 13);
        run_transform(1'b1, 1'b0, 1'b0, 0, 13);
        run_transform(1'b0, 1'b1, 1'b0, 0, 16);
        run_transform(1'b0, 1'b0, 1'b1, 0, 13);
        run_transform(1'b1, 1'b0, 1'b0, 0, 13);

        run_transform(1'b0, 1'b0, 1'b0, 10, 13);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("reset_hold_done", {31'd0, done}, 32'd0);
            check_val("reset_hold_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0;
        run_transform(1'b0, 1'b0, 1'b0, 0, 13);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be exactly as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle request to sequence one 8-point transform
- inv  input  1  1 = inverse transform (conjugate twiddles); sampled only when start is accepted
- ready  input  1  downstream butterfly accepts the current step
- busy  output  1  high from start acceptance until done
- valid  output  1  step outputs are meaningful
- stage  output  2  radix-2 stage index, 0..2
- addr_a  output  3  upper butterfly operand index
- addr_b  output  3  lower butterfly operand index
- w  output  3  twiddle index for the twiddle ROM (W8^w; rew/imw Q1.7 lookup)
- last  output  1  current step is the final butterfly of stage 2
- done  output  1  one-cycle pulse after the final handshake

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-004 In IDLE, start=1 SHALL be accepted, inv SHALL be latched, and the FSM SHALL move to RUN; valid SHALL rise on the next cycle with stage=0 and butterfly j=0.
REQ-005 start SHALL be ignored while in RUN or DONE.
REQ-006 In RUN, a handshake is valid&ready; each handshake SHALL advance to the next step; with no handshake, all step outputs SHALL hold stable.
REQ-007 The step order SHALL be stage 0..2 (outer loop) and butterfly j 0..3 (inner loop), 12 steps in total.
REQ-008 Per step, with span = 1<<stage, grp = j>>stage and pos = j & (span-1):
- addr_a = grp*2*span + pos
- addr_b = addr_a + span
REQ-009 The twiddle exponent SHALL be k = pos << (2-stage). For inv=0, w = k; for inv=1, w = (8-k) mod 8, 3-bit wrap, so that k=0 gives w=0.
REQ-010 last SHALL be high only for stage=2, j=3, while valid=1.
REQ-011 The handshake on the last step SHALL deassert valid and move the FSM to DONE; in DONE, done=1 for exactly one cycle, then the FSM SHALL return to IDLE with busy=0.
REQ-012 The j counter SHALL wrap 3->0 and increment stage in the same cycle; stage SHALL never reach 3.
REQ-013 When valid=0, stage, addr_a, addr_b, w and last SHALL be driven to 0.
REQ-014 ready SHALL be ignored when valid=0.
REQ-015 A start arriving in the same cycle as done=1 SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-016 Minimum transform time with ready held at 1 SHALL be: start cycle, 12 step cycles, 1 done cycle.

Reset
REQ-017 While rst=1, regardless of clk, the FSM SHALL be IDLE and busy, valid, stage, addr_a, addr_b, w, last, done and the latched inv SHALL all be 0.
REQ-018 A reset asserted mid-RUN SHALL abort the transform immediately with no done pulse, and the block SHALL accept start on the first clock after rst is released.

Verification
REQ-019 Forward transform, ready=1: start with inv=0 -> 12 consecutive valid steps:
- stage0: (a,b,w) = (0,1,0) (2,3,0) (4,5,0) (6,7,0)
- stage1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
- stage2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
- then last=1 on the final step and done one cycle after it.
REQ-020 Inverse transform: start with inv=1 -> stage1 w sequence 0,6,0,6 and stage2 w sequence 0,7,6,5; addresses identical to REQ-019.
REQ-021 Backpressure: ready=0 for 3 cycles at stage1 j=1 -> outputs hold (1,3,2) with valid=1 for all stalled cycles; the sequence resumes unchanged and done arrives 3 cycles later than in REQ-019.
REQ-022 Ignored start: start pulsed during RUN and again in the done cycle -> no restart and an unchanged sequence; start on the next IDLE cycle begins a new transform.
REQ-023 Reset mid-operation: rst asserted at stage2 j=1 -> all outputs 0 asynchronously, no done pulse; a start after release gives the full REQ-019 sequence.
